// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory that answers one load/store at a
// time after WAIT_CYCLES wait states, for exercising a core against a stalling
// memory port.
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o   request handshake; addr/we/wdata sampled on accept
//   resp_valid_o/ready_i  response handshake; rdata/err held until taken
//   busy_o                high whenever a transaction is in flight
module dmem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              busy_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WORD_W = ADDR_W - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] mem_d [DEPTH_WORDS];

  logic [WORD_W-1:0] req_word_c;
  logic              req_err_c;

  // Access error: not word-aligned, or word index beyond the array.
  always_comb begin
    req_word_c = req_addr_i[ADDR_W-1:2];
    req_err_c  = (req_addr_i[1:0] != 2'b00) ||
                 (req_word_c >= WORD_W'(DEPTH_WORDS));
  end

  // Next-state, datapath and memory update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_d        = mem_q;

    case (state_q)
      S_IDLE: begin
        // req_ready is always high in IDLE, so valid alone means accept.
        if (req_valid_i) begin
          idx_d   = req_addr_i[IDX_W+1:2];
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          err_d   = req_err_c;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_BUSY : S_EXEC;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!err_q && we_q) begin
          mem_d[idx_q] = wdata_q;
        end
        resp_rdata_d = (!err_q && !we_q) ? mem_q[idx_q] : '0;
        resp_err_d   = err_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset also clears the whole memory.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      mem_q        <= mem_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Instance 0 uses two
// wait states, instance 1 uses zero; both share clock and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int compared   = 0;
  int mismatched = 0;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_we_i(req_we[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .busy_o(busy[0])
  );

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_we_i(req_we[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction with resp_ready held high; exp_n is the number of
  // edges after the accepting edge until resp_valid is seen.
  task automatic xact(input int s, input string tag, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_n);
    int n;
    chk({tag, "_ready"}, 32'(req_ready[s]), 32'd1);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    tick();
    req_valid[s] = 1'b0;
    req_wdata[s] = 32'h0;
    n = 0;
    while (!resp_valid[s] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_rdata"}, resp_rdata[s], exp_rd);
    chk({tag, "_err"}, 32'(resp_err[s]), 32'(exp_err));
    tick();
    chk({tag, "_done"}, {30'd0, resp_valid[s], req_ready[s]}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = 32'h0;
      req_wdata[i]  = 32'h0;
      resp_ready[i] = 1'b1;
    end
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'h0);
    chk("rst_err", 32'(resp_err[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);

    // Basic store then load, two wait states.
    xact(0, "st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    xact(0, "ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Misaligned store must not touch memory.
    xact(0, "st11", 1'b1, 32'h11, 32'h12345678, 32'h0, 1'b1, 3);
    xact(0, "ld10b", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Range boundary: index 128 errors, index 127 works.
    xact(0, "ld200", 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 3);
    xact(0, "st1fc", 1'b1, 32'h1FC, 32'hAAAA5555, 32'h0, 1'b0, 3);
    xact(0, "ld1fc", 1'b0, 32'h1FC, 32'h0, 32'hAAAA5555, 1'b0, 3);

    // Backpressure: response held for 5 cycles, stray request ignored.
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h10;
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("bp_busy", 32'(busy[0]), 32'd1);
    tick();
    tick();
    chk("bp_rise", 32'(resp_valid[0]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h11111111;
      end else begin
        req_valid[0] = 1'b0;
      end
      chk("bp_hold", {req_ready[0], resp_valid[0], resp_err[0], 29'd0}, 32'h40000000);
      chk("bp_rdata", resp_rdata[0], 32'hDEADBEEF);
      tick();
    end
    req_valid[0] = 1'b0;
    chk("bp_still", 32'(resp_valid[0]), 32'd1);
    resp_ready[0] = 1'b1;
    tick();
    chk("bp_release", {30'd0, resp_valid[0], req_ready[0]}, 32'd1);
    chk("bp_rdata0", resp_rdata[0], 32'h0);
    xact(0, "bp_ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Zero wait states: back-to-back stores and loads.
    xact(1, "z_st0", 1'b1, 32'h0, 32'h01010101, 32'h0, 1'b0, 1);
    xact(1, "z_st4", 1'b1, 32'h4, 32'h02020202, 32'h0, 1'b0, 1);
    xact(1, "z_ld0", 1'b0, 32'h0, 32'h0, 32'h01010101, 1'b0, 1);
    xact(1, "z_ld4", 1'b0, 32'h4, 32'h0, 32'h02020202, 1'b0, 1);

    // Reset while in BUSY during a store.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'hCAFEF00D;
    tick();
    req_valid[0] = 1'b0;
    chk("mr_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ready", 32'(req_ready[0]), 32'd1);
    chk("mr_outs", {29'd0, resp_valid[0], resp_err[0], busy[0]}, 32'd0);
    chk("mr_rdata", resp_rdata[0], 32'h0);
    xact(0, "mr_ld20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3);
    xact(0, "mr_ld10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 3);

    // Reset wins over a simultaneous request.
    rst = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h0;
    tick();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    chk("rp_busy", 32'(busy[0]), 32'd0);
    chk("rp_ready", 32'(req_ready[0]), 32'd1);
    tick();
    chk("rp_idle", {31'd0, resp_valid[0]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder. It sits on the slave side of the CPU's load/store port.
- Accepts one request at a time over a valid/ready request channel.
- Services each request after a programmable number of wait states, then returns the result over a valid/ready response channel.
- Replaces the zero-latency data memory, so the core's memory stage can be tested against realistic, stalling memory.

Parameters:
ADDR_W, 32, request address width in bits
DEPTH_WORDS, 128, number of 32-bit words stored
WAIT_CYCLES, 2, wait states between acceptance and response (0 legal, max 15)

Ports:
clk_i  input  1  clock, rising-edge
rst_i  input  1  synchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  responder can accept a request
req_addr_i  input  ADDR_W  byte address
req_we_i  input  1  1 = store, 0 = load
req_wdata_i  input  32  store data
resp_valid_o  output  1  response present
resp_ready_i  input  1  requester takes the response
resp_rdata_o  output  32  load data (0 for stores and errors)
resp_err_o  output  1  misaligned or out-of-range access
busy_o  output  1  transaction in flight (state != IDLE)

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high (rst_i). All state updates on the rising edge.
- Reset values:
  - state = IDLE, req_ready_o = 1.
  - resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0, busy_o = 0.
  - wait counter = 0; all memory words = 0.
- State IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch addr, we and wdata, and compute err = (addr[1:0] != 0) | (addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - Load counter with WAIT_CYCLES. Go to BUSY if WAIT_CYCLES > 0, else EXEC.
- State BUSY:
  - req_ready_o = 0.
  - Counter decrements each cycle; when it reaches 1, next state is EXEC.
  - Request inputs are ignored; only latched values are used.
- State EXEC (one cycle):
  - If !err & we: write wdata to mem[index] at this edge.
  - If !err & !we: resp_rdata_o <= mem[index].
  - Otherwise: resp_rdata_o <= 0.
  - resp_err_o <= err; resp_valid_o <= 1; go to RESP.
- State RESP:
  - resp_valid_o = 1. resp_rdata_o and resp_err_o stay stable until handshake.
  - On resp_valid_o & resp_ready_i: resp_valid_o <= 0, resp_rdata_o <= 0, resp_err_o <= 0, go to IDLE.
  - req_ready_o = 0 in RESP, so no new acceptance in the handshake cycle.
- Latency:
  - Request accepted at edge N gives resp_valid_o high after edge N+1+WAIT_CYCLES.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles when resp_ready_i is held high.
- Errored stores never modify memory. Errored loads return 0.
- Read-after-write to the same address in back-to-back transactions returns the new data, because the write commits in EXEC before the later read.
- A request with req_valid_i dropped before acceptance is ignored. Inputs outside IDLE have no effect.
- Reset mid-transaction:
  - Abandons the transaction and returns to IDLE with reset values.
  - A store not yet in EXEC is not performed.
  - Memory is cleared regardless.
  - Reset asserted in the same cycle as req_valid_i takes priority; the request is not accepted.
- busy_o = 1 in BUSY, EXEC and RESP.
- Word index = addr[ADDR_W-1:2]. No byte enables; all accesses are full-word.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10, then load 0x10, with WAIT_CYCLES=2 and resp_ready_i=1.
  - Store response: err=0, rdata=0, resp_valid_o high 3 cycles after acceptance.
  - Load response: rdata=0xDEADBEEF.
- Misaligned store 0x12345678 to 0x11, then load 0x10 holding 0xDEADBEEF.
  - Store response: err=1, rdata=0.
  - Load response: 0xDEADBEEF unchanged.
- Load from 0x200 (index 128 >= DEPTH_WORDS) -> err=1, rdata=0.
  - Store to 0x1FC (index 127) succeeds: err=0, and readback matches.
- Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid_o rises.
  - resp_valid_o, rdata and err stay stable; req_ready_o=0 throughout.
  - A req_valid_i pulse during this time is ignored.
  - Release resp_ready_i -> IDLE next cycle.
- WAIT_CYCLES=0 build: load accepted at edge N -> resp_valid_o high after edge N+1.
  - Back-to-back stores to 0x0 and 0x4 then loads: each load returns its own data.
- Assert rst_i while in BUSY during a store of 0xCAFEF00D to 0x20.
  - All outputs return to reset values next cycle; req_ready_o=1.
  - A subsequent load of 0x20 returns 0.
